// File: rtl/jpeg_byte_stuffer.sv
// JPEG scan byte stuffer: serialises packed entropy words MSB-byte first, inserts 0x00 after
// every 0xFF data byte and optionally closes each frame with the EOI marker FF D9.
module jpeg_byte_stuffer #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned EMIT_EOI = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  input  logic [$clog2(WORD_W/8):0]   in_bytes,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic                        out_last,
  output logic                        frame_done,
  output logic [15:0]                 stuff_cnt
);

  localparam int unsigned NB = WORD_W / 8;
  localparam int unsigned BW = $clog2(NB) + 1;
  localparam logic [BW-1:0] NB_B = BW'(NB);

  typedef enum logic [2:0] {StIdle, StData, StStuff, StEoiFf, StEoiD9} state_e;

  state_e            state_q, state_d, adv_state;
  logic [WORD_W-1:0] word_q;
  logic [BW-1:0]     idx_q, idx_d, adv_idx, nbytes_q, last_idx;
  logic              final_q, new_frame_q, frame_done_q;
  logic [15:0]       stuff_cnt_q;
  logic [7:0]        cur_byte;
  logic              at_end, stuff_inc, hs;

  always_comb begin
    cur_byte = 8'h00;
    for (int unsigned i = 0; i < NB; i++) begin
      if (idx_q == BW'(i)) cur_byte = word_q[WORD_W-1-8*i -: 8];
    end
  end

  assign last_idx = nbytes_q - BW'(1);
  assign at_end   = (idx_q == last_idx);
  assign hs       = out_valid && out_ready;

  // Where to go once the current data byte (and its stuff byte, if any) has been consumed.
  always_comb begin
    adv_idx   = idx_q;
    adv_state = StIdle;
    if (!at_end) begin
      adv_idx   = idx_q + BW'(1);
      adv_state = StData;
    end else if (final_q && (EMIT_EOI != 0)) begin
      adv_state = StEoiFf;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    stuff_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        out_valid = 1'b1;
        out_data  = cur_byte;
        out_last  = (EMIT_EOI == 0) && final_q && at_end && (cur_byte != 8'hFF);
        if (out_ready) begin
          if (cur_byte == 8'hFF) begin
            state_d = StStuff;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end
      StStuff: begin
        out_valid = 1'b1;
        out_last  = (EMIT_EOI == 0) && final_q && at_end;
        if (out_ready) begin
          stuff_inc = 1'b1;
          state_d   = adv_state;
          idx_d     = adv_idx;
        end
      end
      StEoiFf: begin
        out_valid = 1'b1;
        out_data  = 8'hFF;
        if (out_ready) state_d = StEoiD9;
      end
      StEoiD9: begin
        out_valid = 1'b1;
        out_data  = 8'hD9;
        out_last  = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      word_q       <= '0;
      idx_q        <= '0;
      nbytes_q     <= NB_B;
      final_q      <= 1'b0;
      stuff_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      new_frame_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= hs && out_last;
      if (hs && out_last) new_frame_q <= 1'b1;
      if (in_valid && in_ready) begin
        word_q      <= in_data;
        final_q     <= in_last;
        nbytes_q    <= (in_last && in_bytes != '0 && in_bytes <= NB_B) ? in_bytes : NB_B;
        new_frame_q <= 1'b0;
        if (new_frame_q) stuff_cnt_q <= '0;
      end else if (stuff_inc && stuff_cnt_q != 16'hFFFF) begin
        stuff_cnt_q <= stuff_cnt_q + 16'd1;
      end
    end
  end

  assign frame_done = frame_done_q;
  assign stuff_cnt  = stuff_cnt_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: one instance with EOI, one without, selected by sel.
module tb_jpeg_byte_stuffer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready, sel;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;

  logic        in_ready0, out_valid0, out_last0, frame_done0;
  logic        in_ready1, out_valid1, out_last1, frame_done1;
  logic [7:0]  out_data0, out_data1;
  logic [15:0] stuff_cnt0, stuff_cnt1;

  logic        m_in_ready, m_out_valid, m_out_last, m_frame_done;
  logic [7:0]  m_out_data;
  logic [15:0] m_stuff_cnt;

  logic [7:0]  cap_d[$];
  bit          cap_l[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  jpeg_byte_stuffer #(.WORD_W(32), .EMIT_EOI(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
    .frame_done(frame_done0), .stuff_cnt(stuff_cnt0)
  );

  jpeg_byte_stuffer #(.WORD_W(32), .EMIT_EOI(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .frame_done(frame_done1), .stuff_cnt(stuff_cnt1)
  );

  assign m_in_ready   = sel ? in_ready1   : in_ready0;
  assign m_out_valid  = sel ? out_valid1  : out_valid0;
  assign m_out_data   = sel ? out_data1   : out_data0;
  assign m_out_last   = sel ? out_last1   : out_last0;
  assign m_frame_done = sel ? frame_done1 : frame_done0;
  assign m_stuff_cnt  = sel ? stuff_cnt1  : stuff_cnt0;

  // Record every byte that will be handshaken at the following rising edge.
  always @(negedge clk) begin
    if (!rst && m_out_valid && out_ready) begin
      cap_d.push_back(m_out_data);
      cap_l.push_back(m_out_last);
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL accept_timeout: in_ready=0, expected 1"); end
  endtask

  task automatic wait_last();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (cap_l.size() > 0 && cap_l[$]) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL last_timeout: no out_last handshake, expected one"); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || out_last0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b data=%h last=%b, expected 0 00 0",
               out_valid0, out_data0, out_last0);
    end
    n_checks++;
    if (frame_done0 !== 1'b0 || stuff_cnt0 !== 16'd0 || in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl: fd=%b stuff=%0d in_ready=%b, expected 0 0 1",
               frame_done0, stuff_cnt0, in_ready0);
    end
    n_checks++;
    if (stuff_cnt1 !== 16'd0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: stuff=%0d in_ready=%b valid=%b, expected 0 1 0",
               stuff_cnt1, in_ready1, out_valid1);
    end
  endtask

  task automatic test_plain();
    logic [7:0] exp[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hD9};
    cap_d.delete(); cap_l.delete();
    drive_word(32'h12345678, 1'b1, 3'd4);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL plain_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL plain_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1 || m_stuff_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL plain_done: fd=%b stuff=%0d, expected 1 0", m_frame_done, m_stuff_cnt);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b0) begin
      n_fail++; $display("FAIL plain_pulse: fd=%b, expected 0", m_frame_done);
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] exp[$] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hD9};
    cap_d.delete(); cap_l.delete();
    drive_word(32'hFF00FFAB, 1'b1, 3'd3);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL stuff_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL stuff_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1 || m_stuff_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stuff_done: fd=%b stuff=%0d, expected 1 2", m_frame_done, m_stuff_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'hFF, 8'h00, 8'hFF, 8'hD9};
    cap_d.delete(); cap_l.delete();
    drive_word(32'hAABBCCDD, 1'b0, 3'd0);
    @(negedge clk); #1;
    n_checks++;
    if (m_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy: in_ready=%b, expected 0", m_in_ready);
    end
    drive_word(32'h11FF2233, 1'b1, 3'd2);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL b2b_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1 || m_stuff_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_done: fd=%b stuff=%0d, expected 1 1", m_frame_done, m_stuff_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hD9};
    bit         prev_stall = 1'b0;
    bit         done = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    cap_d.delete(); cap_l.delete();
    out_ready = 1'b1;
    drive_word(32'hFF00FFAB, 1'b1, 3'd3);
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1; out_ready = ~out_ready;
      @(negedge clk); #1;
      if (prev_stall) begin
        n_checks++;
        if (m_out_valid !== 1'b1 || m_out_data !== prev_d || m_out_last !== prev_l) begin
          n_fail++;
          $display("FAIL bp_stable: got %b %h/%b, expected 1 %h/%b", m_out_valid, m_out_data,
                   m_out_last, prev_d, prev_l);
        end
      end
      prev_stall = m_out_valid && !out_ready;
      prev_d     = m_out_data;
      prev_l     = m_out_last;
      done       = cap_l.size() > 0 && cap_l[$];
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL bp_timeout: no out_last, expected one"); end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1) begin
      n_fail++; $display("FAIL bp_done: fd=%b, expected 1", m_frame_done);
    end
    out_ready = 1'b1;
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL bp_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp[$] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hD9};
    bit ok = 1'b0;
    cap_d.delete(); cap_l.delete();
    drive_word(32'h12345678, 1'b1, 3'd4);
    for (int i = 0; i < 50; i++) begin
      if (cap_d.size() >= 2) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mrst_timeout: got <2 bytes, expected 2"); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (m_out_valid !== 1'b0 || m_stuff_cnt !== 16'd0 || m_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_state: valid=%b stuff=%0d in_ready=%b, expected 0 0 1",
               m_out_valid, m_stuff_cnt, m_in_ready);
    end
    cap_d.delete(); cap_l.delete();
    drive_word(32'h000000FF, 1'b1, 3'd4);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL mrst_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL mrst_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1 || m_stuff_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mrst_done: fd=%b stuff=%0d, expected 1 1", m_frame_done, m_stuff_cnt);
    end
  endtask

  task automatic test_zero_bytes();
    logic [7:0] exp[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
    cap_d.delete(); cap_l.delete();
    drive_word(32'h01020304, 1'b1, 3'd0);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL zb_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i]) begin
        n_fail++; $display("FAIL zb_byte%0d: got %h, expected %h", i, cap_d[i], exp[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_no_eoi();
    logic [7:0] exp[$] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    sel = 1'b1;
    cap_d.delete(); cap_l.delete();
    drive_word(32'h000000FF, 1'b1, 3'd4);
    wait_last();
    n_checks++;
    if (cap_d.size() != exp.size()) begin
      n_fail++; $display("FAIL noeoi_len: got %0d, expected %0d", cap_d.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        n_fail++;
        $display("FAIL noeoi_byte%0d: got %h/%b, expected %h/%b", i, cap_d[i], cap_l[i],
                 exp[i], i == exp.size() - 1);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b1 || m_stuff_cnt !== 16'd1 || m_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noeoi_done: fd=%b stuff=%0d valid=%b, expected 1 1 0",
               m_frame_done, m_stuff_cnt, m_out_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_frame_done !== 1'b0) begin
      n_fail++; $display("FAIL noeoi_pulse: fd=%b, expected 0", m_frame_done);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_bytes = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_plain();
    test_stuffing();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_zero_bytes();
    test_no_eoi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning packed entropy-word width in bits, a multiple of 8, at least 16.
REQ-002 The block SHALL have parameter EMIT_EOI, default 1, meaning append the EOI marker FF D9 after each frame when 1.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the packed word from the fixed-length packer is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the word this cycle.
REQ-007 The block SHALL have port in_data, input, WORD_W bits, meaning the packed word; byte 0 = in_data[WORD_W-1:WORD_W-8], sent first.
REQ-008 The block SHALL have port in_last, input, 1 bit, meaning this is the final word of the frame.
REQ-009 The block SHALL have port in_bytes, input, $clog2(WORD_W/8)+1 bits, meaning the count of valid leading bytes in the final word; it is used only when in_last=1.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the downstream accepts a byte.
REQ-012 The block SHALL have port out_data, output, 8 bits, meaning the stuffed JPEG scan byte.
REQ-013 The block SHALL have port out_last, output, 1 bit, meaning the final byte of the frame.
REQ-014 The block SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse when the frame is complete.
REQ-015 The block SHALL have port stuff_cnt, output, 16 bits, meaning the number of 0x00 bytes stuffed in the current or most recent frame.

Function
REQ-016 A word SHALL be accepted when in_valid && in_ready.
- in_ready=1 only in state IDLE.
- On acceptance, in_data is latched, the byte index is set to 0, and the byte count nbytes is set.
- nbytes = in_bytes if in_last=1, else WORD_W/8.
- If in_last=1 and in_bytes is 0 or greater than WORD_W/8, nbytes SHALL be WORD_W/8.
REQ-017 The state machine SHALL have the states IDLE, DATA, STUFF, EOI_FF and EOI_D9.
REQ-018 IDLE SHALL behave as follows: out_valid=0; a word accept moves to DATA, and out_valid rises the next cycle (latency 1).
REQ-019 DATA SHALL present byte[index] of the latched word, with out_valid=1.
- On handshake, if the byte is 0xFF, move to STUFF.
- Otherwise apply the advance rule (REQ-021).
REQ-020 STUFF SHALL present 0x00, with out_valid=1.
- On handshake, increment stuff_cnt, saturating at 0xFFFF.
- Then apply the advance rule (REQ-021).
REQ-021 Advance rule:
- If index < nbytes-1: index+1, stay in or return to DATA.
- Else, if the word is not the final word: go to IDLE.
- Else, if EMIT_EOI=1: go to EOI_FF.
- Else: go to IDLE (frame end).
REQ-022 EOI_FF SHALL present 0xFF; on handshake it moves to EOI_D9. No stuffing SHALL be applied to EOI bytes.
REQ-023 EOI_D9 SHALL present 0xD9 with out_last=1; on handshake it moves to IDLE (frame end).
REQ-024 When EMIT_EOI=0, out_last SHALL be 1 on the last output byte of the final word. That byte is the STUFF 0x00 if the final data byte is 0xFF.
REQ-025 frame_done SHALL be 1 for exactly one cycle, in the cycle after the handshake of the out_last byte.
REQ-026 While out_valid && !out_ready, out_data, out_last and the state SHALL hold stable.
REQ-027 stuff_cnt SHALL clear on acceptance of the first word of a frame (the first word after reset or after a frame end). Otherwise it holds its value between frames.
REQ-028 Sustained throughput SHALL be 1 byte per cycle within a word, with exactly one idle cycle per word (the IDLE accept cycle).
REQ-029 out_valid SHALL never depend combinationally on out_ready. in_ready SHALL depend on state only.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set: state IDLE, out_valid=0, out_data=0x00, out_last=0, frame_done=0, stuff_cnt=0, index=0. in_ready SHALL be 1 from the next cycle.
REQ-031 A reset mid-frame SHALL discard the latched word and any pending stuff or EOI bytes without emitting them. The next accepted word starts a new frame.

Verification
(All scenarios use WORD_W=32 and EMIT_EOI=1 unless stated otherwise.)
REQ-032 The bench SHALL cover: in_data=0x12345678, in_last=1, in_bytes=4, out_ready=1 -> 12 34 56 78 FF D9; out_last on D9; frame_done the next cycle; stuff_cnt=0.
REQ-033 The bench SHALL cover: in_data=0xFF00FFAB, in_last=1, in_bytes=3 -> FF 00 00 FF 00 FF D9; stuff_cnt=2; AB not emitted.
REQ-034 The bench SHALL cover: two words 0xAABBCCDD (in_last=0) then 0x11FF2233 (in_last=1, in_bytes=2) -> AA BB CC DD 11 FF 00 FF D9; in_ready=0 while bytes are pending; stuff_cnt=1.
REQ-035 The bench SHALL cover: scenario REQ-033 with out_ready toggling 1,0,1,0,... -> the same byte sequence; out_data and out_last stable during every stalled cycle.
REQ-036 The bench SHALL cover: rst=1 after 2 bytes of scenario REQ-032 -> out_valid=0 the next cycle, stuff_cnt=0, in_ready=1; a following word 0x000000FF (in_bytes=4) -> 00 00 00 FF 00 FF D9.
REQ-037 The bench SHALL cover: EMIT_EOI=0, in_data=0x000000FF, in_last=1, in_bytes=4 -> 00 00 00 FF 00; out_last on the final 00; frame_done one cycle later.
